// File: rtl/vp_validate_queue.sv
// In-order validation queue: buffers value predictions, pairs each with its committed
// value, returns a registered training update. Optional stats: define VP_VALIDATE_STATS_EN.
module vp_validate_queue #(
  parameter int P_NUM_PRED = 2,
  parameter int P_DEPTH    = 16,
  parameter int P_PC_W     = 32,
  parameter int P_DATA_W   = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [P_NUM_PRED-1:0]          fw_valid_i,
  input  logic [P_NUM_PRED*P_PC_W-1:0]   fw_pc_i,
  input  logic [P_NUM_PRED*P_DATA_W-1:0] fw_pred_i,
  input  logic [P_NUM_PRED-1:0]          fw_conf_i,
  output logic                           fw_ready_o,
  input  logic                           cm_valid_i,
  input  logic [P_DATA_W-1:0]            cm_value_i,
  input  logic                           flush_i,
  output logic                           bw_valid_o,
  output logic [P_PC_W-1:0]              bw_pc_o,
  output logic [P_DATA_W-1:0]            bw_value_o,
  output logic                           bw_correct_o,
  output logic                           mispred_o,
  output logic [$clog2(P_DEPTH):0]       count_o,
  output logic                           err_o
`ifdef VP_VALIDATE_STATS_EN
  ,
  output logic [31:0]                    stat_correct_o,
  output logic [31:0]                    stat_mispred_o
`endif
);

  localparam int AW = $clog2(P_DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]       head_q, tail_q;
  logic [P_PC_W-1:0]   pc_mem   [P_DEPTH];
  logic [P_DATA_W-1:0] pred_mem [P_DEPTH];
  logic                conf_mem [P_DEPTH];

  logic                empty;
  logic                alloc_en;
  logic                cm_fire;
  logic                cm_underflow;
  logic [PW-1:0]       alloc_num;
  logic [PW-1:0]       lane_off [P_NUM_PRED];
  logic [AW-1:0]       wr_idx   [P_NUM_PRED];
  logic [AW-1:0]       head_idx;
  logic                head_correct;

  // Wrap bits make tail-head the exact occupancy, including the full case.
  assign count_o    = tail_q - head_q;
  assign empty      = (head_q == tail_q);
  assign fw_ready_o = (count_o <= PW'(P_DEPTH - P_NUM_PRED));
  assign head_idx   = head_q[AW-1:0];

  assign alloc_en     = (|fw_valid_i) && fw_ready_o && !flush_i;
  assign cm_fire      = cm_valid_i && !empty && !flush_i;
  assign cm_underflow = cm_valid_i && empty && !flush_i;
  assign head_correct = (pred_mem[head_idx] == cm_value_i);

  // Compact valid lanes: each lane's slot offset is the number of older valid lanes.
  always_comb begin
    // NOTE: alloc_num is a running sum, so blocking assignments are required here; the
    // default before the loop also keeps every path assigned and avoids a latch.
    alloc_num = '0;
    for (int n = 0; n < P_NUM_PRED; n++) begin
      lane_off[n] = alloc_num;
      wr_idx[n]   = AW'(tail_q + alloc_num);
      if (fw_valid_i[n]) alloc_num = alloc_num + PW'(1);
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
    end else if (flush_i) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (alloc_en) tail_q <= tail_q + alloc_num;
      if (cm_fire)  head_q <= head_q + PW'(1);
    end
  end

  // NOTE: the payload array has no reset; an entry is only read after it was written,
  // and leaving it unreset keeps it mappable onto plain RAM.
  always_ff @(posedge clk_i) begin
    for (int n = 0; n < P_NUM_PRED; n++) begin
      if (alloc_en && fw_valid_i[n]) begin
        pc_mem[wr_idx[n]]   <= fw_pc_i[n*P_PC_W +: P_PC_W];
        pred_mem[wr_idx[n]] <= fw_pred_i[n*P_DATA_W +: P_DATA_W];
        conf_mem[wr_idx[n]] <= fw_conf_i[n];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bw_valid_o   <= 1'b0;
      bw_pc_o      <= '0;
      bw_value_o   <= '0;
      bw_correct_o <= 1'b0;
      mispred_o    <= 1'b0;
    end else begin
      bw_valid_o <= cm_fire;
      mispred_o  <= cm_fire && conf_mem[head_idx] && !head_correct;
      if (cm_fire) begin
        bw_pc_o      <= pc_mem[head_idx];
        bw_value_o   <= cm_value_i;
        bw_correct_o <= head_correct;
      end
    end
  end

  // Sticky: only reset clears it, flush leaves it alone.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)             err_o <= 1'b0;
    else if (cm_underflow) err_o <= 1'b1;
  end

`ifdef VP_VALIDATE_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_correct_o <= '0;
      stat_mispred_o <= '0;
    end else begin
      if (bw_valid_o && bw_correct_o && (stat_correct_o != '1))
        stat_correct_o <= stat_correct_o + 32'd1;
      if (mispred_o && (stat_mispred_o != '1))
        stat_mispred_o <= stat_mispred_o + 32'd1;
    end
  end
`endif

endmodule
